trng_rosc_meter: RTL and testbench

Parametrised ring-oscillator measurement and divider block in the TRNG entropy path, running entirely in the rnd_src_clk domain. It provides a programmable, debug-gated divided oscillator output and a free-running oscillator cycle counter. The counter is snapshotted into NUM_WIN capture registers on window markers (toggles) issued from the rng_clk domain. It replaces fixed 3-window, fixed-width BIST counting with configurable width, window count and synchroniser depth, plus simultaneous capture, clear and overflow reporting.

---
 rtl/trng_rosc_pkg.sv | 10 +
 rtl/trng_sync_ff.sv | 25 ++
 rtl/trng_rosc_meter.sv | 155 +++++++++++++++
 tb/tb_trng_rosc_meter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_rosc_pkg.sv
// Default geometry of the ring-oscillator meter, shared by the meter and its synchronisers.
package trng_rosc_pkg;

    localparam int CNT_W_DEF       = 22;
    localparam int DIV_W_DEF       = 14;
    localparam int NUM_WIN_DEF     = 3;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DIV_SEL_W       = 4;

endpackage

// File: rtl/trng_sync_ff.sv
// Reset-to-0 multi-flop bit synchroniser into the rnd_src_clk domain.
module trng_sync_ff
    import trng_rosc_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic rnd_src_clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge rnd_src_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trng_rosc_meter.sv
// Ring-oscillator divider plus cycle counter with NUM_WIN toggle-triggered capture windows.
// Window/clear toggles act SYNC_STAGES+1 edges after they change; TRNG_ROSC_CNT_SAT_EN makes the counter saturate instead of wrap.
module trng_rosc_meter
    import trng_rosc_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int NUM_WIN     = NUM_WIN_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                     rnd_src_clk,
    input  logic                     rst_n,
    input  logic                     rnd_src_en,
    input  logic                     rng_debug_enable,
    input  logic [DIV_SEL_W-1:0]     div_sel,
    input  logic [NUM_WIN-1:0]       win_tgl,
    input  logic                     clr_tgl,
    output logic                     divided_rnd_src,
    output logic [NUM_WIN*CNT_W-1:0] cntr_val,
    output logic [NUM_WIN-1:0]       cntr_vld,
    output logic                     cntr_ovf
);

    logic               en_s;
    logic               clr_s;
    logic [NUM_WIN-1:0] win_s;
    logic [NUM_WIN-1:0] win_p_q;
    logic               clr_p_q;
    logic [NUM_WIN-1:0] win_ev;
    logic               clr_ev;

    trng_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_en (
        .rnd_src_clk (rnd_src_clk),
        .rst_n       (rst_n),
        .d_i         (rnd_src_en),
        .q_o         (en_s)
    );

    trng_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_clr (
        .rnd_src_clk (rnd_src_clk),
        .rst_n       (rst_n),
        .d_i         (clr_tgl),
        .q_o         (clr_s)
    );

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win_sync
        trng_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_win (
            .rnd_src_clk (rnd_src_clk),
            .rst_n       (rst_n),
            .d_i         (win_tgl[w]),
            .q_o         (win_s[w])
        );
    end

    always_ff @(posedge rnd_src_clk or negedge rst_n) begin
        if (!rst_n) begin
            win_p_q <= '0;
            clr_p_q <= 1'b0;
        end else begin
            win_p_q <= win_s;
            clr_p_q <= clr_s;
        end
    end

    assign win_ev = win_s ^ win_p_q;
    assign clr_ev = clr_s ^ clr_p_q;

    logic [DIV_W-1:0]     div_cntr_q, div_cntr_d;
    logic [DIV_SEL_W-1:0] tap;
    logic                 tap_bit;

    assign div_cntr_d = en_s ? div_cntr_q + 1'b1 : '0;
    // Out-of-range selects clamp to the top divider bit.
    assign tap = (32'(div_sel) > DIV_W - 1) ? DIV_SEL_W'(DIV_W - 1) : div_sel;

    always_comb begin
        tap_bit = 1'b0;
        for (int i = 0; i < DIV_W; i++) begin
            if (32'(tap) == i) begin
                tap_bit = div_cntr_q[i];
            end
        end
    end

    assign divided_rnd_src = tap_bit & rng_debug_enable;

    logic [CNT_W-1:0] rosc_cntr_q, rosc_cntr_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        rosc_cntr_d = rosc_cntr_q;
        ovf_d       = ovf_q;
        if (clr_ev) begin
            rosc_cntr_d = '0;
            ovf_d       = 1'b0;
        end else if (en_s) begin
            if (&rosc_cntr_q) begin
                ovf_d = 1'b1;
`ifdef TRNG_ROSC_CNT_SAT_EN
                rosc_cntr_d = rosc_cntr_q;
`else
                rosc_cntr_d = '0;
`endif
            end else begin
                rosc_cntr_d = rosc_cntr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rnd_src_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cntr_q  <= '0;
            rosc_cntr_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            div_cntr_q  <= div_cntr_d;
            rosc_cntr_q <= rosc_cntr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cntr_ovf = ovf_q;

    // All windows sample the same pre-increment count; a clear in the same cycle suppresses capture.
    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        logic [CNT_W-1:0] val_q, val_d;
        logic             vld_q, vld_d;

        always_comb begin
            val_d = val_q;
            vld_d = vld_q;
            if (clr_ev) begin
                val_d = '0;
                vld_d = 1'b0;
            end else if (win_ev[w]) begin
                val_d = rosc_cntr_q;
                vld_d = 1'b1;
            end
        end

        always_ff @(posedge rnd_src_clk or negedge rst_n) begin
            if (!rst_n) begin
                val_q <= '0;
                vld_q <= 1'b0;
            end else begin
                val_q <= val_d;
                vld_q <= vld_d;
            end
        end

        assign cntr_val[w*CNT_W +: CNT_W] = val_q;
        assign cntr_vld[w]                = vld_q;
    end

endmodule

// File: tb/tb_trng_rosc_meter.sv
// Directed bench: a default instance and a 4-bit-counter instance driven by the same stimulus.
module tb_trng_rosc_meter;

`ifdef TRNG_ROSC_CNT_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        dbg = 1'b0;
    logic [3:0]  div_sel = 4'd0;
    logic [2:0]  win_tgl = 3'b000;
    logic        clr_tgl = 1'b0;

    logic        a_div, b_div;
    logic [65:0] a_val;
    logic [11:0] b_val;
    logic [2:0]  a_vld, b_vld;
    logic        a_ovf, b_ovf;

    int edges = 0;
    int en_at = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trng_rosc_meter dut_a (
        .rnd_src_clk      (clk),
        .rst_n            (rst_n),
        .rnd_src_en       (en),
        .rng_debug_enable (dbg),
        .div_sel          (div_sel),
        .win_tgl          (win_tgl),
        .clr_tgl          (clr_tgl),
        .divided_rnd_src  (a_div),
        .cntr_val         (a_val),
        .cntr_vld         (a_vld),
        .cntr_ovf         (a_ovf)
    );

    trng_rosc_meter #(.CNT_W(4)) dut_b (
        .rnd_src_clk      (clk),
        .rst_n            (rst_n),
        .rnd_src_en       (en),
        .rng_debug_enable (dbg),
        .div_sel          (div_sel),
        .win_tgl          (win_tgl),
        .clr_tgl          (clr_tgl),
        .divided_rnd_src  (b_div),
        .cntr_val         (b_val),
        .cntr_vld         (b_vld),
        .cntr_ovf         (b_ovf)
    );

    function automatic logic [21:0] av(input int i);
        return a_val[i*22 +: 22];
    endfunction

    function automatic logic [3:0] bv(input int i);
        return b_val[i*4 +: 4];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        edges += n;
    endtask

    task automatic test_reset;
        tick(2);
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL rst_div: got %b expected 0", a_div); end
        n_vec++; if (a_val !== 66'd0) begin n_err++; $display("FAIL rst_val: got %h expected 0", a_val); end
        n_vec++; if (a_vld !== 3'b000) begin n_err++; $display("FAIL rst_vld: got %b expected 000", a_vld); end
        n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", a_ovf); end
        n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL rst_b_ovf: got %b expected 0", b_ovf); end
        rst_n = 1'b1;
        tick(3);
        n_vec++; if (a_vld !== 3'b000) begin n_err++; $display("FAIL idle_vld: got %b expected 000", a_vld); end
    endtask

    task automatic test_capture;
        logic [3:0] eb;
        eb = SAT_BUILD ? 4'd15 : 4'd6;
        en = 1'b1;
        en_at = edges;
        tick(102);
        win_tgl ^= 3'b001;
        tick(2);
        n_vec++; if (a_vld !== 3'b000) begin n_err++; $display("FAIL cap_early_vld: got %b expected 000", a_vld); end
        tick(1);
        n_vec++; if (a_vld !== 3'b001) begin n_err++; $display("FAIL cap_vld: got %b expected 001", a_vld); end
        n_vec++; if (av(0) !== 22'd102) begin n_err++; $display("FAIL cap_val0: got %0d expected 102", av(0)); end
        n_vec++; if (bv(0) !== eb) begin n_err++; $display("FAIL cap_b_val0: got %0d expected %0d", bv(0), eb); end
    endtask

    task automatic test_multi_window;
        logic [3:0] eb;
        eb = SAT_BUILD ? 4'd15 : 4'd9;
        win_tgl ^= 3'b110;
        tick(2);
        n_vec++; if (a_vld !== 3'b001) begin n_err++; $display("FAIL multi_early_vld: got %b expected 001", a_vld); end
        tick(1);
        n_vec++; if (a_vld !== 3'b111) begin n_err++; $display("FAIL multi_vld: got %b expected 111", a_vld); end
        n_vec++; if (av(1) !== 22'd105) begin n_err++; $display("FAIL multi_val1: got %0d expected 105", av(1)); end
        n_vec++; if (av(2) !== 22'd105) begin n_err++; $display("FAIL multi_val2: got %0d expected 105", av(2)); end
        n_vec++; if (av(0) !== 22'd102) begin n_err++; $display("FAIL multi_val0_kept: got %0d expected 102", av(0)); end
        n_vec++; if (bv(2) !== eb) begin n_err++; $display("FAIL multi_b_val2: got %0d expected %0d", bv(2), eb); end
    endtask

    task automatic test_clear_vs_capture;
        n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL pre_clr_b_ovf: got %b expected 1", b_ovf); end
        clr_tgl ^= 1'b1;
        win_tgl ^= 3'b001;
        tick(2);
        n_vec++; if (a_vld !== 3'b111) begin n_err++; $display("FAIL clr_early_vld: got %b expected 111", a_vld); end
        tick(1);
        n_vec++; if (a_vld !== 3'b000) begin n_err++; $display("FAIL clr_vld: got %b expected 000", a_vld); end
        n_vec++; if (a_val !== 66'd0) begin n_err++; $display("FAIL clr_val: got %h expected 0", a_val); end
        n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL clr_b_ovf: got %b expected 0", b_ovf); end
        n_vec++; if (b_val !== 12'd0) begin n_err++; $display("FAIL clr_b_val: got %h expected 0", b_val); end
        win_tgl ^= 3'b001;
        tick(3);
        n_vec++; if (a_vld !== 3'b001) begin n_err++; $display("FAIL restart_vld: got %b expected 001", a_vld); end
        n_vec++; if (av(0) !== 22'd2) begin n_err++; $display("FAIL restart_val0: got %0d expected 2", av(0)); end
        n_vec++; if (bv(0) !== 4'd2) begin n_err++; $display("FAIL restart_b_val0: got %0d expected 2", bv(0)); end
    endtask

    task automatic test_overflow;
        logic [3:0] e1, e2;
        e1 = SAT_BUILD ? 4'd15 : 4'd0;
        e2 = SAT_BUILD ? 4'd15 : 4'd3;
        tick(11);
        n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at14: got %b expected 0", b_ovf); end
        win_tgl ^= 3'b010;
        tick(1);
        n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at15: got %b expected 0", b_ovf); end
        tick(1);
        n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", b_ovf); end
        n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_a_clear: got %b expected 0", a_ovf); end
        tick(1);
        n_vec++; if (bv(1) !== e1) begin n_err++; $display("FAIL ovf_b_val1: got %0d expected %0d", bv(1), e1); end
        n_vec++; if (av(1) !== 22'd16) begin n_err++; $display("FAIL ovf_a_val1: got %0d expected 16", av(1)); end
        n_vec++; if (b_vld !== 3'b011) begin n_err++; $display("FAIL ovf_b_vld: got %b expected 011", b_vld); end
        win_tgl ^= 3'b100;
        tick(3);
        n_vec++; if (av(2) !== 22'd19) begin n_err++; $display("FAIL ovf_a_val2: got %0d expected 19", av(2)); end
        n_vec++; if (bv(2) !== e2) begin n_err++; $display("FAIL ovf_b_val2: got %0d expected %0d", bv(2), e2); end
        clr_tgl ^= 1'b1;
        tick(2);
        n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b expected 1", b_ovf); end
        tick(1);
        n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %b expected 0", b_ovf); end
        n_vec++; if (b_vld !== 3'b000) begin n_err++; $display("FAIL ovf_clr_vld: got %b expected 000", b_vld); end
    endtask

    task automatic test_en_drop_divider;
        logic exp_d;
        tick(10);
        en = 1'b0;
        dbg = 1'b1;
        div_sel = 4'd0;
        tick(48);
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL div_cleared_a: got %b expected 0", a_div); end
        tick(1);
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL div_cleared_b: got %b expected 0", a_div); end
        tick(1);
        win_tgl ^= 3'b001;
        tick(3);
        n_vec++; if (av(0) !== 22'd12) begin n_err++; $display("FAIL en_hold_val0: got %0d expected 12", av(0)); end
        en = 1'b1;
        div_sel = 4'd2;
        en_at = edges;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
            exp_d = (k >= 2) && ((((k - 2) / 4) % 2) == 1);
            n_vec++;
            if (a_div !== exp_d) begin
                n_err++;
                $display("FAIL div8_edge%0d: got %b expected %b", k, a_div, exp_d);
            end
        end
        win_tgl ^= 3'b010;
        tick(3);
        n_vec++; if (av(1) !== 22'd36) begin n_err++; $display("FAIL en_resume_val1: got %0d expected 36", av(1)); end
        dbg = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            n_vec++;
            if (a_div !== 1'b0) begin
                n_err++;
                $display("FAIL div_gated%0d: got %b expected 0", k, a_div);
            end
        end
    endtask

    task automatic test_div_tap;
        div_sel = 4'd15;
        dbg = 1'b1;
        tick(en_at + 8193 - edges);
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL tap15_8191: got %b expected 0", a_div); end
        tick(1);
        n_vec++; if (a_div !== 1'b1) begin n_err++; $display("FAIL tap15_8192: got %b expected 1", a_div); end
        n_vec++; if (b_div !== 1'b1) begin n_err++; $display("FAIL tap15_b_8192: got %b expected 1", b_div); end
        div_sel = 4'd13;
        #1;
        n_vec++; if (a_div !== 1'b1) begin n_err++; $display("FAIL tap13_8192: got %b expected 1", a_div); end
        div_sel = 4'd12;
        #1;
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL tap12_8192: got %b expected 0", a_div); end
        div_sel = 4'd15;
        #1;
    endtask

    task automatic test_reset_mid;
        win_tgl ^= 3'b001;
        tick(1);
        n_vec++; if (a_vld !== 3'b011) begin n_err++; $display("FAIL pre_rst_vld: got %b expected 011", a_vld); end
        n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL pre_rst_b_ovf: got %b expected 1", b_ovf); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL mid_rst_div: got %b expected 0", a_div); end
        n_vec++; if (a_val !== 66'd0) begin n_err++; $display("FAIL mid_rst_val: got %h expected 0", a_val); end
        n_vec++; if (a_vld !== 3'b000) begin n_err++; $display("FAIL mid_rst_vld: got %b expected 000", a_vld); end
        n_vec++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL mid_rst_b_ovf: got %b expected 0", b_ovf); end
        n_vec++; if (b_val !== 12'd0) begin n_err++; $display("FAIL mid_rst_b_val: got %h expected 0", b_val); end
        win_tgl = 3'b000;
        clr_tgl = 1'b0;
        en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        n_vec++; if (a_vld !== 3'b000) begin n_err++; $display("FAIL post_rst_vld: got %b expected 000", a_vld); end
        n_vec++; if (a_div !== 1'b0) begin n_err++; $display("FAIL post_rst_div: got %b expected 0", a_div); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_multi_window();
        test_clear_vs_capture();
        test_overflow();
        test_en_drop_divider();
        test_div_tap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
